mac_row_feeder: RTL

- West-edge transmitter for one row of the weight-stationary MAC array.
- Drives the row's first tile `in_w` / `inst_w` pair: `inst_w[0]` = kernel load, `inst_w[1]` = execute.
- Pulls operands from an upstream valid/ready source (L0 row buffer). Issues `col` kernel words, then `n_exec` activation words, then drains the row.
- One instance per array row, sequenced by the core controller via `start`/`done`.

---
 rtl/mac_row_feeder.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/mac_row_feeder.sv
// mac_row_feeder
// ---------------------------------------------------------------------------
// West-edge transmitter for one row of the weight-stationary MAC array.
// A pass streams `col` kernel words (inst_w = 01) followed by `n_exec`
// activation words (inst_w = 10) into the row's first tile, then idles the
// row for `col` cycles so the last instruction leaves the east tile, then
// pulses `done`.
//
// Handshake: a word moves from upstream when in_valid & in_ready are both
// high at a rising clk edge. in_ready depends on state only (never on
// in_valid), and in_data is ignored on any cycle without an accept.
//
// Ports
//   clk        clock
//   reset      asynchronous reset, active low (0 = in reset)
//   start      1-cycle pulse, begins a pass; ignored unless idle
//   n_exec     activation count, sampled when start is accepted
//   in_data    operand from upstream
//   in_valid   upstream has a word
//   in_ready   feeder accepts a word this cycle
//   out_w      to tile in_w (registered)
//   inst_w     to tile inst_w (registered): [0] kernel load, [1] execute
//   busy       high in every state except idle
//   done       1-cycle pulse at the end of the drain
//   dbg_state  current FSM state (0 idle, 1 load, 2 exec, 3 drain, 4 fin)
// ---------------------------------------------------------------------------
module mac_row_feeder #(
   parameter int bw     = 4,
   parameter int col    = 8,
   parameter int cnt_bw = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [cnt_bw-1:0] n_exec,
   input  logic [bw-1:0]     in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [bw-1:0]     out_w,
   output logic [1:0]        inst_w,
   output logic              busy,
   output logic              done,
   output logic [2:0]        dbg_state
);

   // One counter serves both the load phase and the drain phase; they never
   // overlap, and it is cleared on every hand-over between them.
   localparam int            CW   = (col > 1) ? $clog2(col) : 1;
   localparam logic [CW-1:0] LAST = CW'(col - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_EXEC  = 3'd2,
      S_DRAIN = 3'd3,
      S_FIN   = 3'd4
   } state_t;

   state_t              state_q, state_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [cnt_bw-1:0]   exec_left_q, exec_left_d;
   logic [bw-1:0]       out_w_q, out_w_d;
   logic [1:0]          inst_w_q, inst_w_d;
   logic                accept;

   // ------------------------------------------------------------------
   // State register and registered datapath
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         exec_left_q <= '0;
         out_w_q     <= '0;
         inst_w_q    <= 2'b00;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         exec_left_q <= exec_left_d;
         out_w_q     <= out_w_d;
         inst_w_q    <= inst_w_d;
      end
   end

   assign accept = in_valid & in_ready;

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      exec_left_d = exec_left_q;
      out_w_d     = out_w_q;   // out_w holds through bubbles and drain
      inst_w_d    = 2'b00;     // no accept means a bubble the tiles ignore

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d     = S_LOAD;
               exec_left_d = n_exec;
               cnt_d       = '0;
            end
         end

         S_LOAD: begin
            if (accept) begin
               out_w_d  = in_data;
               inst_w_d = 2'b01;
               if (cnt_q == LAST) begin
                  cnt_d   = '0;
                  state_d = (exec_left_q != '0) ? S_EXEC : S_DRAIN;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
         end

         S_EXEC: begin
            if (accept) begin
               out_w_d     = in_data;
               inst_w_d    = 2'b10;
               exec_left_d = exec_left_q - cnt_bw'(1);
               // Leaving on the last word means the counter never wraps,
               // even for the all-ones count.
               if (exec_left_q == cnt_bw'(1)) begin
                  state_d = S_DRAIN;
               end
            end
         end

         S_DRAIN: begin
            // col idle cycles let the final instruction walk out of the
            // east tile before done is raised.
            if (cnt_q == LAST) begin
               cnt_d   = '0;
               state_d = S_FIN;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end

         S_FIN: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Output logic (state-only outputs plus registered tile drive)
   // ------------------------------------------------------------------
   always_comb begin
      in_ready  = (state_q == S_LOAD) | (state_q == S_EXEC);
      busy      = (state_q != S_IDLE);
      done      = (state_q == S_FIN);
      out_w     = out_w_q;
      inst_w    = inst_w_q;
      dbg_state = state_q;
   end

endmodule
